// File: rtl/im2col_pkg.sv
// im2col_pkg: shared feature-map geometry constants and scheduler state encoding.
package im2col_pkg;
  localparam int IMG_H = 28;
  localparam int IMG_W = 28;
  localparam int K = 3;
  localparam int STRIDE = 1;
  localparam int OUT_ROWS = (IMG_H - K) / STRIDE + 1;
  localparam int ROW_W = $clog2(OUT_ROWS);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/im2col_tag_fifo.sv
// im2col_tag_fifo: small synchronous FIFO holding row tags of rows in flight.
module im2col_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 5
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_empty,
  output logic         o_full
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic w_push, w_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign o_dout = r_mem[r_rp];
  assign o_empty = r_cnt == '0;
  assign o_full = r_cnt == CW'(DEPTH);
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_mem[r_wp] <= i_din;
      if (w_push) r_wp <= nxt(r_wp);
      if (w_pop) r_rp <= nxt(r_rp);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/im2col_row_sched.sv
// im2col_row_sched: issues output-row indices to the im2col engine and tags returned rows.
module im2col_row_sched
  import im2col_pkg::*;
#(
  parameter int MAX_OUT = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_aborted,
  output logic             o_err,
  output logic             o_im_valid,
  input  logic             i_im_ready,
  output logic [ROW_W-1:0] o_row_idx,
  input  logic             i_im_post_valid,
  output logic             o_im_post_ready,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [ROW_W-1:0] o_out_row
);
  localparam int CW = ROW_W + 1;
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] N = CW'(OUT_ROWS);
  localparam logic [CW-1:0] LAST = CW'(OUT_ROWS - 1);
  state_t r_state;
  logic [CW-1:0] r_issue, r_ret;
  logic [OW-1:0] r_out;
  logic r_done, r_aborted, r_err;
  logic w_empty, w_full, w_issue, w_ret, w_start;
  assign w_start = r_state == IDLE && i_start;
  assign o_im_valid = r_state == RUN && !i_abort && r_issue < N && r_out < OW'(MAX_OUT) && !w_full;
  assign w_issue = o_im_valid && i_im_ready;
  assign o_row_idx = ROW_W'(r_issue * STRIDE);
  assign o_out_valid = i_im_post_valid && !w_empty;
  assign o_im_post_ready = i_out_ready && !w_empty;
  assign w_ret = i_im_post_valid && i_out_ready && !w_empty;
  assign o_busy = r_state != IDLE;
  assign o_done = r_done;
  assign o_aborted = r_aborted;
  assign o_err = r_err;
  im2col_tag_fifo #(.DEPTH(MAX_OUT), .W(ROW_W)) u_fifo (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_push(w_issue),
    .i_pop(w_ret),
    .i_din(ROW_W'(r_issue)),
    .o_dout(o_out_row),
    .o_empty(w_empty),
    .o_full(w_full)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_issue <= '0;
      r_ret <= '0;
      r_out <= '0;
      r_done <= 1'b0;
      r_aborted <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_aborted <= 1'b0;
      r_err <= (w_start ? 1'b0 : r_err) | (i_im_post_valid && w_empty);
      r_issue <= w_start ? '0 : r_issue + CW'(w_issue);
      r_ret <= w_start ? '0 : r_ret + CW'(w_ret);
      r_out <= r_out + OW'(w_issue) - OW'(w_ret);
      unique case (r_state)
        IDLE: if (i_start) r_state <= RUN;
        RUN: begin
          // abort wins over a same-cycle final return
          if (i_abort) r_state <= DRAIN;
          else if (w_ret && r_ret == LAST) begin
            r_state <= IDLE;
            r_done <= 1'b1;
          end
        end
        DRAIN: begin
          if (r_out == '0 || (r_out == OW'(1) && w_ret)) begin
            r_state <= IDLE;
            r_aborted <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_im2col_row_sched.sv
// tb_im2col_row_sched: randomized scoreboard bench for the im2col row scheduler.
module tb_im2col_row_sched;
  import im2col_pkg::*;
  localparam int MAX_OUT = 2;
  logic i_clk = 1'b0, i_rst_n = 1'b0;
  logic i_start = 1'b0, i_abort = 1'b0, i_im_ready = 1'b0, i_im_post_valid = 1'b0, i_out_ready = 1'b0;
  logic o_busy, o_done, o_aborted, o_err, o_im_valid, o_im_post_ready, o_out_valid;
  logic [ROW_W-1:0] o_row_idx, o_out_row;
  int checks = 0, errors = 0;
  int exp_q[$];
  bit exp_err = 1'b0;
  im2col_row_sched #(.MAX_OUT(MAX_OUT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
    .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted), .o_err(o_err),
    .o_im_valid(o_im_valid), .i_im_ready(i_im_ready), .o_row_idx(o_row_idx),
    .i_im_post_valid(i_im_post_valid), .o_im_post_ready(o_im_post_ready),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_row(o_out_row)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_im_valid"}, o_im_valid, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_aborted"}, o_aborted, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_out_valid"}, o_out_valid, 0);
    chk({tag, "_post_ready"}, o_im_post_ready, 0);
    chk({tag, "_row_idx"}, o_row_idx, 0);
    chk({tag, "_out_row"}, o_out_row, 0);
  endtask
  // monitor: every accepted return must carry the oldest issued tag
  always @(negedge i_clk) begin
    int e;
    #2;
    if (o_out_valid && i_out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_row_unexpected actual=%0d expected=none", o_out_row);
      end else begin
        e = exp_q.pop_front();
        chk("out_row", o_out_row, e);
      end
    end
  end
  // modes: 0 nominal, 1 downstream stall, 2 toggling ready, 3 random, 4 abort at row 10
  task automatic run_case(input int mode, input int stop_at);
    int phase = 0, issued = 0, rets = 0, outst = 0, tail = 0, last_due = 0, d, prev_row = 0;
    bit exp_done = 0, exp_abd = 0, prev_stall = 0, abort_sent = 0, saw_sat = 0, iss, ret, exp_valid;
    int eng_q[$];
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge i_clk);
      if (cyc == stop_at) return;
      i_start = cyc == 0;
      i_im_ready = mode == 2 ? cyc[0] : mode == 3 ? 1'($urandom_range(0, 1)) : 1'b1;
      i_out_ready = mode == 1 ? !(cyc >= 10 && cyc < 20) :
                    mode == 3 ? ($urandom_range(0, 3) != 0) :
                    mode == 4 ? !(rets >= 8 && outst > 0 && !abort_sent) : 1'b1;
      i_abort = mode == 4 && phase == 1 && !abort_sent && issued == 10 && outst == 2;
      i_im_post_valid = eng_q.size() > 0 && eng_q[0] <= cyc;
      #1;
      exp_valid = phase == 1 && !i_abort && issued < OUT_ROWS && outst < MAX_OUT;
      chk("busy", o_busy, int'(phase != 0));
      chk("im_valid", o_im_valid, exp_valid);
      chk("done", o_done, exp_done);
      chk("aborted", o_aborted, exp_abd);
      chk("err", o_err, exp_err);
      chk("out_valid", o_out_valid, int'(i_im_post_valid && outst > 0));
      chk("post_ready", o_im_post_ready, int'(i_out_ready && outst > 0));
      if (exp_valid) chk("row_idx", o_row_idx, issued * STRIDE);
      if (prev_stall) chk("row_hold", o_row_idx, prev_row);
      if (phase == 1 && outst == MAX_OUT && !o_im_valid) saw_sat = 1;
      iss = exp_valid && i_im_ready;
      ret = i_im_post_valid && i_out_ready && outst > 0;
      prev_stall = exp_valid && !i_im_ready;
      prev_row = issued * STRIDE;
      exp_done = 0;
      exp_abd = 0;
      if (i_start && phase == 0) exp_err = 0;
      if (i_im_post_valid && outst == 0) exp_err = 1;
      if (ret) begin
        void'(eng_q.pop_front());
        rets++;
        outst--;
      end
      if (iss) begin
        d = (mode == 2 || mode == 3) ? $urandom_range(1, 4) : 2;
        last_due = (cyc + d > last_due) ? cyc + d : last_due;
        eng_q.push_back(last_due);
        exp_q.push_back(issued);
        issued++;
        outst++;
      end
      if (phase == 0 && i_start) phase = 1;
      else if (phase == 1 && i_abort) begin
        phase = 2;
        abort_sent = 1;
      end else if (phase == 1 && ret && rets == OUT_ROWS) begin
        phase = 0;
        exp_done = 1;
      end else if (phase == 2 && outst == 0) begin
        phase = 0;
        exp_abd = 1;
      end
      if (phase == 0 && cyc > 0) tail++;
      if (tail == 3) break;
    end
    i_start = 0;
    i_abort = 0;
    i_im_post_valid = 0;
    if (tail < 3) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=running expected=idle mode=%0d", mode);
    end
    chk("issued", issued, mode == 4 ? 10 : OUT_ROWS);
    chk("returned", rets, mode == 4 ? 10 : OUT_ROWS);
    chk("scoreboard_empty", exp_q.size(), 0);
    if (mode == 1) chk("saturated", saw_sat, 1);
  endtask
  initial begin
    repeat (3) @(negedge i_clk);
    #1 chk_all_zero("reset");
    i_rst_n = 1'b1;
    @(negedge i_clk);
    #1 chk_all_zero("post_reset");
    run_case(0, -1);
    run_case(0, 8);
    i_rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    exp_q.delete();
    i_start = 0;
    i_abort = 0;
    i_im_post_valid = 0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_case(1, -1);
    run_case(2, -1);
    run_case(4, -1);
    @(negedge i_clk);
    i_im_post_valid = 1;
    i_out_ready = 1;
    #1;
    chk("spur_out_valid", o_out_valid, 0);
    chk("spur_post_ready", o_im_post_ready, 0);
    exp_err = 1;
    @(negedge i_clk);
    i_im_post_valid = 0;
    #1 chk("spur_err", o_err, 1);
    run_case(0, -1);
    run_case(3, -1);
    run_case(3, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
